// File: rtl/operand_bus_arbiter.sv
// Two-requester arbiter for a shared 16-bit operand bus with bounded burst fairness
// and a single registered output stage.
module operand_bus_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        sel,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready
);

    typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

    localparam logic       LastA    = 1'b0;
    localparam logic       LastB    = 1'b1;
    localparam logic [3:0] BurstMax = 4'(BURST_MAX);

    state_e      r_state;
    state_e      w_state_d;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_d;
    logic        r_last;
    logic        w_last_d;
    logic        r_out_valid;
    logic [15:0] r_out_data;

    logic        w_cap_en;
    logic        w_burst_done;
    logic [3:0]  w_cnt_inc;
    logic        w_gnt_a;
    logic        w_gnt_b;

    assign w_cap_en     = !r_out_valid || out_ready;
    assign w_burst_done = (r_cnt == BurstMax);
    // Saturate so a lone requester cannot push cnt past the burst limit.
    assign w_cnt_inc    = (r_cnt >= BurstMax) ? BurstMax : r_cnt + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_last  <= LastB;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_last  <= w_last_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_last_d  = r_last;
        if (w_cap_en) begin
            if (w_gnt_a) begin
                w_state_d = StOwnA;
                w_last_d  = LastA;
                w_cnt_d   = (r_state == StOwnA) ? w_cnt_inc : 4'd1;
            end else if (w_gnt_b) begin
                w_state_d = StOwnB;
                w_last_d  = LastB;
                w_cnt_d   = (r_state == StOwnB) ? w_cnt_inc : 4'd1;
            end else begin
                w_state_d = StIdle;
                w_cnt_d   = 4'd0;
            end
        end
    end

    // Grant outputs; gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (rst_n && w_cap_en) begin
            case (r_state)
                StIdle: begin
                    if (req_a && req_b) begin
                        w_gnt_a = (r_last == LastB);
                        w_gnt_b = (r_last == LastA);
                    end else begin
                        w_gnt_a = req_a;
                        w_gnt_b = req_b;
                    end
                end
                StOwnA: begin
                    if (req_a && !(req_b && w_burst_done)) w_gnt_a = 1'b1;
                    else if (req_b)                        w_gnt_b = 1'b1;
                end
                StOwnB: begin
                    if (req_b && !(req_a && w_burst_done)) w_gnt_b = 1'b1;
                    else if (req_a)                        w_gnt_a = 1'b1;
                end
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_b = 1'b0;
                end
            endcase
        end
    end

    // Output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
        end else if (w_gnt_a || w_gnt_b) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_b ? data_b : data_a;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign gnt_a     = w_gnt_a;
    assign gnt_b     = w_gnt_b;
    assign sel       = w_gnt_b;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Directed bench: per-cycle vector table against a BURST_MAX=4 instance, plus hand
// sequences for strict alternation (BURST_MAX=1) and asynchronous mid-burst reset.
module tb_operand_bus_arbiter;

    typedef struct {
        logic        rst;
        logic        ra;
        logic        rb;
        logic        rdy;
        logic [15:0] da;
        logic [15:0] db;
        logic        ga;
        logic        gb;
        logic        ov;
        logic [15:0] od;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_a, req_b, out_ready;
    logic [15:0] data_a, data_b;

    logic        gnt_a4, gnt_b4, sel4, ov4;
    logic [15:0] od4;
    logic        gnt_a1, gnt_b1, sel1, ov1;
    logic [15:0] od1;

    int errors;
    int checks;
    vec_t vq[$];

    operand_bus_arbiter #(.BURST_MAX(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .data_a   (data_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .gnt_a    (gnt_a4),
        .gnt_b    (gnt_b4),
        .sel      (sel4),
        .out_valid(ov4),
        .out_data (od4),
        .out_ready(out_ready)
    );

    operand_bus_arbiter #(.BURST_MAX(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .data_a   (data_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .gnt_a    (gnt_a1),
        .gnt_b    (gnt_b1),
        .sel      (sel1),
        .out_valid(ov1),
        .out_data (od1),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ra, input logic rb, input logic rdy,
                       input logic [15:0] da, input logic [15:0] db, input logic ga,
                       input logic gb, input logic ov, input logic [15:0] od);
        vec_t v;
        v.rst = rst; v.ra = ra; v.rb = rb; v.rdy = rdy; v.da = da; v.db = db;
        v.ga = ga; v.gb = gb; v.ov = ov; v.od = od;
        vq.push_back(v);
    endtask

    task automatic ab(input logic ra, input logic rb, input logic rdy, input logic ga,
                      input logic gb, input logic ov, input logic [15:0] od);
        add(1'b0, ra, rb, rdy, 16'hAAAA, 16'hBBBB, ga, gb, ov, od);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        out_ready = 1'b0;
        data_a    = 16'h0000;
        data_b    = 16'h0000;

        // Reset state with a request pending, then single grant to A
        add(1'b1, 1, 0, 1, 16'h1234, 16'h0000, 0, 0, 0, 16'h0000);
        add(1'b0, 1, 0, 1, 16'h1234, 16'h0000, 1, 0, 0, 16'h0000);
        add(1'b0, 0, 0, 1, 16'h1234, 16'h0000, 0, 0, 1, 16'h1234);
        // Fresh reset, contended burst A x4, B x4, A
        add(1'b1, 1, 1, 1, 16'hAAAA, 16'hBBBB, 0, 0, 0, 16'h0000);
        ab(1, 1, 1, 1, 0, 0, 16'h0000);
        ab(1, 1, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 0, 1, 1, 16'hAAAA);
        ab(1, 1, 1, 0, 1, 1, 16'hBBBB);
        ab(1, 1, 1, 0, 1, 1, 16'hBBBB);
        ab(1, 1, 1, 0, 1, 1, 16'hBBBB);
        ab(1, 1, 1, 1, 0, 1, 16'hBBBB);
        // Five stalled cycles, then the burst count resumes (A x3 more, then B)
        for (int i = 0; i < 5; i++) ab(1, 1, 0, 0, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 0, 1, 1, 16'hAAAA);
        // Owner handover when the owner drops, then idle and output drain
        ab(1, 0, 1, 1, 0, 1, 16'hBBBB);
        ab(1, 0, 1, 1, 0, 1, 16'hAAAA);
        ab(0, 1, 1, 0, 1, 1, 16'hAAAA);
        ab(0, 0, 1, 0, 0, 1, 16'hBBBB);
        ab(0, 0, 1, 0, 0, 0, 16'hBBBB);
        // Empty output stage grants even when out_ready is low; full one does not
        ab(1, 0, 0, 1, 0, 0, 16'hBBBB);
        ab(1, 0, 0, 0, 0, 1, 16'hAAAA);
        ab(0, 0, 1, 0, 0, 1, 16'hAAAA);
        // Lone requester saturates cnt at BURST_MAX; B then wins immediately
        ab(1, 0, 1, 1, 0, 0, 16'hAAAA);
        ab(1, 0, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 0, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 0, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 0, 1, 1, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 0, 1, 1, 16'hAAAA);
        ab(1, 1, 1, 0, 1, 1, 16'hBBBB);
        // Idle tie-break honours last owner
        ab(0, 0, 1, 0, 0, 1, 16'hBBBB);
        ab(1, 0, 1, 1, 0, 0, 16'hBBBB);
        ab(0, 0, 1, 0, 0, 1, 16'hAAAA);
        ab(1, 1, 1, 0, 1, 0, 16'hAAAA);
        ab(0, 0, 1, 0, 0, 1, 16'hBBBB);

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n     = !vq[i].rst;
            req_a     = vq[i].ra;
            req_b     = vq[i].rb;
            out_ready = vq[i].rdy;
            data_a    = vq[i].da;
            data_b    = vq[i].db;
            #1;
            check("gnt_a", i, {15'd0, gnt_a4}, {15'd0, vq[i].ga});
            check("gnt_b", i, {15'd0, gnt_b4}, {15'd0, vq[i].gb});
            check("sel", i, {15'd0, sel4}, {15'd0, vq[i].gb});
            check("out_valid", i, {15'd0, ov4}, {15'd0, vq[i].ov});
            check("out_data", i, od4, vq[i].od);
        end

        // BURST_MAX=1: strict alternation from reset
        @(negedge clk);
        rst_n = 1'b0;
        req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
        data_a = 16'hAAAA; data_b = 16'hBBBB;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("alt_gnt_a", i, {15'd0, gnt_a1}, {15'd0, (i % 2 == 0)});
            check("alt_gnt_b", i, {15'd0, gnt_b1}, {15'd0, (i % 2 == 1)});
            if (i > 0) check("alt_out_data", i, od1, (i % 2 == 1) ? 16'hAAAA : 16'hBBBB);
            @(negedge clk);
        end

        // Asynchronous reset in OWN_B with cnt=3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("pre_gnt_a", i, {15'd0, gnt_a4}, {15'd0, (i < 4)});
            check("pre_gnt_b", i, {15'd0, gnt_b4}, {15'd0, (i >= 4)});
            @(negedge clk);
        end
        #2;
        check("mid_out_valid", 0, {15'd0, ov4}, 16'd1);
        check("mid_out_data", 0, od4, 16'hBBBB);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 0, {15'd0, ov4}, 16'd0);
        check("rst_out_data", 0, od4, 16'h0000);
        check("rst_gnt_b", 0, {15'd0, gnt_b4}, 16'd0);
        check("rst_sel", 0, {15'd0, sel4}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_gnt_a", 0, {15'd0, gnt_a4}, 16'd1);
        check("post_gnt_b", 0, {15'd0, gnt_b4}, 16'd0);
        @(negedge clk);
        #1;
        check("post_out_data", 0, od4, 16'hAAAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_bus_arbiter.md
OPERAND_BUS_ARBITER -- requirements
Module: operand_bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4, maximum consecutive grants to one requester while the other requests; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_a  input  1  requester A has a valid 16-bit word on data_a.
REQ-005 data_a  input  16  requester A word, held stable while req_a=1 and gnt_a=0.
REQ-006 req_b  input  1  requester B has a valid word on data_b.
REQ-007 data_b  input  16  requester B word, same stability rule.
REQ-008 gnt_a  output  1  combinational; data_a consumed at this rising edge.
REQ-009 gnt_b  output  1  combinational; data_b consumed at this rising edge.
REQ-010 sel  output  1  select for the shared 16-bit 2:1 operand mux (0=a, 1=b); equals gnt_b.
REQ-011 out_valid  output  1  registered; out_data holds a granted word.
REQ-012 out_data  output  16  registered granted word.
REQ-013 out_ready  input  1  downstream accepts out_data when out_valid=1.

Function
REQ-014 cap_en = !out_valid || out_ready; grants SHALL occur only in cycles with cap_en=1; at most one of gnt_a/gnt_b high.
REQ-015 States: IDLE, OWN_A, OWN_B; 4-bit counter cnt (consecutive grants to current owner); 1-bit last (last owner served).
REQ-016 IDLE, cap_en: both req -> grant the requester != last; one req -> grant it; none -> no grant.
REQ-017 OWN_A, cap_en: req_a && !(req_b && cnt==BURST_MAX) -> grant A; else req_b -> grant B; else no grant. OWN_B symmetric.
REQ-018 On grant to X: next state OWN_X; last=X; cnt = cnt+1 if X is current owner, else 1; cnt never exceeds BURST_MAX.
REQ-019 cap_en=1 with no grant: next state IDLE, cnt=0, last unchanged.
REQ-020 cap_en=0: state, cnt, last, out_valid, out_data hold; gnt_a=gnt_b=0; sel=0.
REQ-021 On grant: out_data <= selected data (data_b if sel else data_a), out_valid <= 1 at that edge (latency 1 cycle gnt->out_valid).
REQ-022 out_valid && out_ready with no grant: out_valid <= 0, out_data holds.
REQ-023 Back-to-back: with out_ready=1 held, one word per cycle throughput.
REQ-024 sel SHALL be 0 whenever no grant is issued.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, cnt=0, last=B, out_valid=0, out_data=16'h0000; gnt_a/gnt_b/sel=0 while rst_n=0.
REQ-026 Reset mid-burst discards the registered word; first grant after release follows REQ-016 with last=B (A wins tie).

Verification
REQ-027 Reset release, req_a=1 data_a=16'h1234, out_ready=1 -> gnt_a=1, sel=0 same cycle; next cycle out_valid=1, out_data=16'h1234.
REQ-028 BURST_MAX=4, req_a=req_b=1 continuous, out_ready=1, data_a=16'hAAAA, data_b=16'hBBBB -> grant sequence A,A,A,A,B,B,B,B,A...; sel tracks B grants.
REQ-029 out_valid=1, out_ready=0 for 5 cycles with both req -> no gnt, out_data stable; out_ready=1 -> grant resumes next cycle, cnt continues.
REQ-030 OWN_A at cnt=2, req_a drops, req_b=1 -> gnt_b next cap_en cycle, cnt=1; both req then deasserted -> IDLE, out_valid falls after acceptance.
REQ-031 BURST_MAX=1, both req continuous -> strict alternation A,B,A,B.
REQ-032 rst_n pulsed low mid-burst (OWN_B, cnt=3) -> out_valid=0 asynchronously; after release with both req, A granted first.
